// File: rtl/ciclo_esp32_encoder.sv
// Timed phase sequencer driving the traffic-light decoder: phase code, flash flag and strobes.
// Optional manual stepping (ports manual/paso) is enabled by defining CICLO_PASO_MANUAL_EN.
module ciclo_esp32_encoder #(
  parameter int N_CICLOS   = 8,
  parameter int T_LARGO    = 50000000,
  parameter int T_CORTO    = 10000000,
  parameter int T_DEST     = 25000000,
  parameter int CICLO_DEST = 31,
  parameter int CW         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dest_req,
`ifdef CICLO_PASO_MANUAL_EN
  input  logic       manual,
  input  logic       paso,
`endif
  output logic [4:0] ciclo_esp32,
  output logic       dest_esp32,
  output logic       ciclo_stb,
  output logic       fin_ronda
);

  typedef enum logic {RUN, DEST} state_t;

  localparam logic [CW-1:0] T_LARGO_FIN = CW'(T_LARGO - 1);
  localparam logic [CW-1:0] T_CORTO_FIN = CW'(T_CORTO - 1);
  localparam logic [CW-1:0] T_DEST_FIN  = CW'(T_DEST - 1);
  localparam logic [4:0]    ULTIMA_FASE = 5'(N_CICLOS - 1);
  localparam logic [4:0]    CODIGO_DEST = 5'(CICLO_DEST);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] t_fin;
  logic          modo_manual;
  logic          avanzar;

  // Odd phases are the short amber dwell, even phases the long green one.
  assign t_fin = ciclo_esp32[0] ? T_CORTO_FIN : T_LARGO_FIN;

`ifdef CICLO_PASO_MANUAL_EN
  assign modo_manual = manual;
  assign avanzar     = en && (manual ? paso : (cnt == t_fin));
`else
  assign modo_manual = 1'b0;
  assign avanzar     = en && (cnt == t_fin);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      ciclo_esp32 <= '0;
      dest_esp32  <= 1'b0;
      ciclo_stb   <= 1'b0;
      fin_ronda   <= 1'b0;
    end else begin
      ciclo_stb <= 1'b0;
      fin_ronda <= 1'b0;
      case (state)
        RUN: begin
          if (avanzar) begin
            cnt       <= '0;
            ciclo_stb <= 1'b1;
            // Flash mode is only entered on a phase boundary, never mid-dwell.
            if (dest_req) begin
              state       <= DEST;
              ciclo_esp32 <= CODIGO_DEST;
              dest_esp32  <= 1'b1;
            end else if (ciclo_esp32 == ULTIMA_FASE) begin
              ciclo_esp32 <= '0;
              fin_ronda   <= 1'b1;
            end else begin
              ciclo_esp32 <= ciclo_esp32 + 5'd1;
            end
          end else if (modo_manual) begin
            cnt <= '0;
          end else if (en) begin
            cnt <= cnt + 1'b1;
          end
        end
        DEST: begin
          // Exit wins over a coincident toggle and does not wait for en.
          if (!dest_req) begin
            state       <= RUN;
            cnt         <= '0;
            ciclo_esp32 <= '0;
            dest_esp32  <= 1'b0;
            ciclo_stb   <= 1'b1;
          end else if (en) begin
            if (cnt == T_DEST_FIN) begin
              cnt        <= '0;
              dest_esp32 <= ~dest_esp32;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ciclo_esp32_encoder.sv
// Randomized bench for ciclo_esp32_encoder against a countdown-based behavioural model.
module tb_ciclo_esp32_encoder;

  localparam int N_CICLOS = 4;
  localparam int T_LARGO  = 10;
  localparam int T_CORTO  = 3;
  localparam int T_DEST   = 4;
  localparam int C_DEST   = 31;

  logic       clk = 1'b0;
  logic       rst, en, dest_req;
  logic [4:0] ciclo_esp32;
  logic       dest_esp32, ciclo_stb, fin_ronda;
`ifdef CICLO_PASO_MANUAL_EN
  logic       manual = 1'b0;
  logic       paso   = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: remaining cycles in the current dwell or half-period.
  bit m_dest;
  int m_phase;
  int m_left;
  bit m_blink;
  bit m_stb;
  bit m_fin;

  always #5 clk = ~clk;

  ciclo_esp32_encoder #(
    .N_CICLOS(N_CICLOS), .T_LARGO(T_LARGO), .T_CORTO(T_CORTO),
    .T_DEST(T_DEST), .CICLO_DEST(C_DEST), .CW(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .dest_req(dest_req),
`ifdef CICLO_PASO_MANUAL_EN
    .manual(manual),
    .paso(paso),
`endif
    .ciclo_esp32(ciclo_esp32),
    .dest_esp32(dest_esp32),
    .ciclo_stb(ciclo_stb),
    .fin_ronda(fin_ronda)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int dwell(input int phase);
    return (phase % 2 == 0) ? T_LARGO : T_CORTO;
  endfunction

  task automatic modelStep(input bit r, input bit e, input bit d);
    m_stb = 0;
    m_fin = 0;
    if (r) begin
      m_dest = 0; m_phase = 0; m_left = T_LARGO; m_blink = 0;
    end else if (!m_dest) begin
      if (e) begin
        m_left--;
        if (m_left == 0) begin
          m_stb = 1;
          if (d) begin
            m_dest = 1; m_blink = 1; m_left = T_DEST;
          end else begin
            m_phase = (m_phase + 1) % N_CICLOS;
            m_fin = (m_phase == 0);
            m_left = dwell(m_phase);
          end
        end
      end
    end else if (!d) begin
      m_dest = 0; m_phase = 0; m_blink = 0; m_left = T_LARGO; m_stb = 1;
    end else if (e) begin
      m_left--;
      if (m_left == 0) begin
        m_blink = !m_blink;
        m_left = T_DEST;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit d);
    @(negedge clk);
    rst = r; en = e; dest_req = d;
    @(posedge clk);
    modelStep(r, e, d);
    #1;
    checkOutput("ciclo_esp32", int'(ciclo_esp32), m_dest ? C_DEST : m_phase);
    checkOutput("dest_esp32", int'(dest_esp32), int'(m_blink));
    checkOutput("ciclo_stb", int'(ciclo_stb), int'(m_stb));
    checkOutput("fin_ronda", int'(fin_ronda), int'(m_fin));
  endtask

  initial begin
    bit r_req;
    rst = 1'b1; en = 1'b1; dest_req = 1'b0;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("reset_ciclo", int'(ciclo_esp32), 0);
    checkOutput("reset_dest", int'(dest_esp32), 0);

    // Free run from reset release against the fixed timeline 10/13/23/26.
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(0, 1, 0);
      case (k)
        9:  checkOutput("tp_before_first", int'(ciclo_esp32), 0);
        10: checkOutput("tp_first_change", int'(ciclo_esp32), 1);
        13: checkOutput("tp_phase2", int'(ciclo_esp32), 2);
        23: checkOutput("tp_phase3", int'(ciclo_esp32), 3);
        26: checkOutput("tp_wrap_fin", int'(fin_ronda), 1);
        default: ;
      endcase
    end

    // Flash entry at a boundary, toggles, exit, and a mid-flash reset.
    applyStimulus(1, 1, 0);
    for (int k = 1; k <= 20; k++) applyStimulus(0, 1, k >= 5);
    checkOutput("tp_in_dest", int'(ciclo_esp32), C_DEST);
    applyStimulus(0, 1, 0);
    checkOutput("tp_dest_exit", int'(ciclo_esp32), 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 1);
    for (int k = 0; k < 10; k++) applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 1);
    checkOutput("tp_rst_in_dest", int'(dest_esp32), 0);

    r_req = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 19) == 0) r_req = !r_req;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, r_req);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
